// File: rtl/clock_time_ctrl_if.sv
// ---------------------------------------------------------------------------
// clock_time_ctrl_if
//   Groups the key inputs and display outputs of clock_time_ctrl.
//   key_mode, key_inc : raw active-high buttons (asynchronous, bouncy)
//   mod               : 00 run, 01 set hours, 10 set minutes
//   bcd_h/bcd_m/bcd_s : time of day, BCD {tens,ones}
//   sec_pulse         : one-cycle strobe with each new seconds value
//   master : key source / display consumer
//   slave  : the time controller
// ---------------------------------------------------------------------------
interface clock_time_ctrl_if;
  logic       key_mode;
  logic       key_inc;
  logic [1:0] mod;
  logic [7:0] bcd_h;
  logic [7:0] bcd_m;
  logic [7:0] bcd_s;
  logic       sec_pulse;

  modport master (
    output key_mode, key_inc,
    input  mod, bcd_h, bcd_m, bcd_s, sec_pulse
  );

  modport slave (
    input  key_mode, key_inc,
    output mod, bcd_h, bcd_m, bcd_s, sec_pulse
  );
endinterface

// File: rtl/clock_time_ctrl.sv
// ---------------------------------------------------------------------------
// clock_time_ctrl
//   Time-of-day keeper for the digital clock: 1 Hz prescaler, BCD
//   seconds/minutes/hours carry chain and a two-key time-set FSM
//   (mode cycles RUN -> SET_H -> SET_M -> RUN, inc bumps the field).
//   Ports:
//     clk  : system clock
//     rst  : asynchronous, active-high reset
//     bus  : clock_time_ctrl_if.slave (keys in; mod, bcd_h/m/s, sec_pulse out)
//   Parameters: TICK_DIV, DEBOUNCE_CYC, REPEAT_DLY, REPEAT_PER.
//   Build option: define AUTO_REPEAT_EN to auto-repeat a held inc key in the
//   set states; otherwise each press gives exactly one increment.
// ---------------------------------------------------------------------------
module clock_time_ctrl #(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned REPEAT_DLY   = 25_000_000,
  parameter int unsigned REPEAT_PER   = 10_000_000
) (
  input  logic                clk,
  input  logic                rst,
  clock_time_ctrl_if.slave    bus
);

  if (TICK_DIV < 2 || DEBOUNCE_CYC < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_param
    $error("clock_time_ctrl: illegal parameter value");
  end

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_SET_H = 2'b01,
    ST_SET_M = 2'b10
  } state_t;

  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYC - 1);

  function automatic logic [7:0] inc_60(input logic [7:0] v);
    if (v == 8'h59)       return 8'h00;
    if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_24(input logic [7:0] v);
    if (v == 8'h23)       return 8'h00;
    if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // ---- key path: index 0 = mode, 1 = inc --------------------------------
  logic [1:0]            key_raw;
  logic [1:0]            sync1_q, sync1_d;
  logic [1:0]            sync2_q, sync2_d;
  logic [1:0]            lvl_q, lvl_d;
  logic [1:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]            press;

  assign key_raw = {bus.key_inc, bus.key_mode};

  always_comb begin
    sync1_d   = key_raw;
    sync2_d   = sync1_q;
    lvl_d     = lvl_q;
    deb_cnt_d = deb_cnt_q;
    press     = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      if (sync2_q[k] == lvl_q[k]) begin
        deb_cnt_d[k] = '0;
      end else if (deb_cnt_q[k] == DEB_MAX) begin
        deb_cnt_d[k] = '0;
        lvl_d[k]     = ~lvl_q[k];
        press[k]     = ~lvl_q[k];
      end else begin
        deb_cnt_d[k] = deb_cnt_q[k] + 1'b1;
      end
    end
  end

  // ---- time / FSM state ---------------------------------------------------
  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [7:0]       h_q, h_d;
  logic [7:0]       m_q, m_d;
  logic [7:0]       s_q, s_d;
  logic             sp_q, sp_d;
  logic             tick;
  logic             inc_evt;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DLY_M1 = RPT_W'(REPEAT_DLY - 1);
  localparam logic [RPT_W-1:0] RPT_PER_M1 = RPT_W'(REPEAT_PER - 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_phase_q, rpt_phase_d;   // 0: initial delay, 1: periodic
  logic             rpt_fire;

  // Counter only runs while the debounced inc level stays high in a set
  // state; a mode press is the only way the state changes, so it clears too.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_phase_d = rpt_phase_q;
    rpt_fire    = 1'b0;
    if (state_q == ST_RUN || !lvl_q[1] || press[0]) begin
      rpt_cnt_d   = '0;
      rpt_phase_d = 1'b0;
    end else if (rpt_cnt_q == (rpt_phase_q ? RPT_PER_M1 : RPT_DLY_M1)) begin
      rpt_fire    = 1'b1;
      rpt_cnt_d   = '0;
      rpt_phase_d = 1'b1;
    end else begin
      rpt_cnt_d   = rpt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt_q   <= '0;
      rpt_phase_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_phase_q <= rpt_phase_d;
    end
  end

  assign inc_evt = press[1] | rpt_fire;
`else
  assign inc_evt = press[1];
`endif

  always_comb begin
    state_d = state_q;
    pre_d   = '0;
    h_d     = h_q;
    m_d     = m_q;
    s_d     = s_q;
    tick    = (state_q == ST_RUN) && (pre_q == PRE_MAX);
    sp_d    = tick;

    if (state_q == ST_RUN && !press[0]) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end

    // Whole carry chain resolves in the tick cycle.
    if (tick) begin
      if (s_q == 8'h59) begin
        s_d = 8'h00;
        if (m_q == 8'h59) begin
          m_d = 8'h00;
          h_d = inc_24(h_q);
        end else begin
          m_d = inc_60(m_q);
        end
      end else begin
        s_d = inc_60(s_q);
      end
    end

    // Mode has priority; a coincident inc is dropped.
    if (press[0]) begin
      case (state_q)
        ST_RUN:   state_d = ST_SET_H;
        ST_SET_H: state_d = ST_SET_M;
        ST_SET_M: begin
          state_d = ST_RUN;
          s_d     = 8'h00;
        end
        default:  state_d = ST_RUN;
      endcase
    end else if (inc_evt) begin
      case (state_q)
        ST_SET_H: h_d = inc_24(h_q);
        ST_SET_M: m_d = inc_60(m_q);
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      lvl_q     <= '0;
      deb_cnt_q <= '0;
      state_q   <= ST_RUN;
      pre_q     <= '0;
      h_q       <= '0;
      m_q       <= '0;
      s_q       <= '0;
      sp_q      <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      lvl_q     <= lvl_d;
      deb_cnt_q <= deb_cnt_d;
      state_q   <= state_d;
      pre_q     <= pre_d;
      h_q       <= h_d;
      m_q       <= m_d;
      s_q       <= s_d;
      sp_q      <= sp_d;
    end
  end

  assign bus.mod       = state_q;
  assign bus.bcd_h     = h_q;
  assign bus.bcd_m     = m_q;
  assign bus.bcd_s     = s_q;
  assign bus.sec_pulse = sp_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_time_ctrl
//   Directed + randomized bench for clock_time_ctrl. A behavioural model
//   (time kept as seconds-of-day, keys judged over a window of raw samples)
//   predicts every output each cycle; directed steps add spot checks.
// ---------------------------------------------------------------------------
module tb_clock_time_ctrl;
  localparam int TD = 4;
  localparam int DB = 3;
  localparam int RD = 20;
  localparam int RP = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clock_time_ctrl_if ifc ();

  clock_time_ctrl #(
    .TICK_DIV    (TD),
    .DEBOUNCE_CYC(DB),
    .REPEAT_DLY  (RD),
    .REPEAT_PER  (RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int          cyc = 0;
  int          exit_cyc = 0;
  int          n_sp = 0;
  int          bad_sp = 0;

  // model state
  int mh, mm, ms, mst, mrun, mheld;
  bit msp;
  bit lvl [2];
  bit hist [2][DB+2];

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mh = 0; mm = 0; ms = 0; mst = 0; mrun = 0; mheld = 0; msp = 0;
    for (int k = 0; k < 2; k++) begin
      lvl[k] = 0;
      for (int i = 0; i < DB + 2; i++) hist[k][i] = 0;
    end
  endtask

  task automatic model_edge();
    bit flip [2];
    bit pr   [2];
    bit rpt;
    bit tick;
    int t;
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      for (int i = DB + 1; i > 0; i--) hist[k][i] = hist[k][i-1];
      hist[k][0] = (k == 0) ? ifc.key_mode : ifc.key_inc;
      // entries 2..DB+1 are the last DB samples seen through the synchroniser
      flip[k] = 1;
      for (int i = 2; i <= DB + 1; i++) if (hist[k][i] == lvl[k]) flip[k] = 0;
      pr[k] = flip[k] && !lvl[k];
    end
    rpt = 0;
`ifdef AUTO_REPEAT_EN
    if (mst != 0 && lvl[1] && !pr[0]) begin
      mheld++;
      if (mheld >= RD && (mheld - RD) % RP == 0) rpt = 1;
    end else begin
      mheld = 0;
    end
`endif
    tick = (mst == 0) && (mrun % TD == TD - 1);
    msp  = tick;
    if (tick) begin
      t  = (mh * 3600 + mm * 60 + ms + 1) % 86400;
      mh = t / 3600;
      mm = (t / 60) % 60;
      ms = t % 60;
    end
    if (pr[0]) begin
      if (mst == 2) begin
        ms = 0;
        exit_cyc = cyc;
      end
      mst  = (mst + 1) % 3;
      mrun = 0;
    end else begin
      if (mst == 0) mrun++;
      if (pr[1] || rpt) begin
        if (mst == 1) mh = (mh + 1) % 24;
        else if (mst == 2) mm = (mm + 1) % 60;
      end
    end
    for (int k = 0; k < 2; k++) lvl[k] = lvl[k] ^ flip[k];
  endtask

  task automatic check_outputs();
    chk("mod",       {6'b0, ifc.mod},       8'(mst));
    chk("bcd_h",     ifc.bcd_h,             to_bcd(mh));
    chk("bcd_m",     ifc.bcd_m,             to_bcd(mm));
    chk("bcd_s",     ifc.bcd_s,             to_bcd(ms));
    chk("sec_pulse", {7'b0, ifc.sec_pulse}, {7'b0, msp});
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_outputs();
    if (ifc.sec_pulse === 1'b1) n_sp++;
    if (ifc.mod !== 2'b00 && ifc.sec_pulse === 1'b1) bad_sp++;
    if (cyc > 40000) begin
      $display("FAIL cycle_budget: got %0d cycles, limit 40000", cyc);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic press(input bit pm, input bit pi);
    int n;
    ifc.key_mode = pm;
    ifc.key_inc  = pi;
    n = DB + 3 + int'($urandom_range(0, 4));
    repeat (n) step();
    ifc.key_mode = 1'b0;
    ifc.key_inc  = 1'b0;
    n = DB + 3 + int'($urandom_range(0, 4));
    repeat (n) step();
  endtask

  // glitches of at most 2 synced cycles never reach the 3-cycle threshold
  task automatic bounce_inc(input int bursts);
    for (int b = 0; b < bursts; b++) begin
      ifc.key_inc = 1'b1;
      repeat (int'($urandom_range(1, 2))) step();
      ifc.key_inc = 1'b0;
      repeat (int'($urandom_range(1, 2))) step();
    end
    repeat (6) step();
  endtask

  initial begin
    int g;
    int h0;
    int op;
    rst = 1'b1;
    ifc.key_mode = 1'b0;
    ifc.key_inc  = 1'b0;
    model_reset();
    repeat (3) step();
    chk("rst_mod", {6'b0, ifc.mod}, 8'h00);
    chk("rst_s",   ifc.bcd_s,       8'h00);
    rst = 1'b0;

    // 1: free run
    n_sp = 0;
    repeat (40) step();
    chk("t1_pulses", 8'(n_sp), 8'd10);
    chk("t1_s",      ifc.bcd_s, 8'h10);
    chk("t1_mod",    {6'b0, ifc.mod}, 8'h00);

    // 2: set 23:59 and roll over
    press(1, 0);
    repeat (23) press(0, 1);
    chk("t2_h", ifc.bcd_h, 8'h23);
    press(1, 0);
    repeat (59) press(0, 1);
    chk("t2_m", ifc.bcd_m, 8'h59);
    press(1, 0);
    chk("t2_mod", {6'b0, ifc.mod}, 8'h00);
    repeat (exit_cyc + 240 - cyc) step();
    chk("t2_h0", ifc.bcd_h, 8'h00);
    chk("t2_m0", ifc.bcd_m, 8'h00);
    chk("t2_s0", ifc.bcd_s, 8'h00);

    // 3: bounce in SET_H, then clean press
    press(1, 0);
    h0 = mh;
    bounce_inc(5);
    chk("t3_bounce_h", ifc.bcd_h, to_bcd(h0));
    ifc.key_inc = 1'b1;
    repeat (10) step();
    ifc.key_inc = 1'b0;
    repeat (8) step();
    chk("t3_clean_h", ifc.bcd_h, to_bcd((h0 + 1) % 24));

    // 4: mode cycling, no seconds activity while setting
    press(1, 0);
    press(1, 0);
    bad_sp = 0;
    press(1, 0);
    chk("t4_mod1", {6'b0, ifc.mod}, 8'h01);
    press(1, 0);
    chk("t4_mod2", {6'b0, ifc.mod}, 8'h02);
    press(1, 0);
    chk("t4_mod0", {6'b0, ifc.mod}, 8'h00);
    chk("t4_no_sp", 8'(bad_sp), 8'd0);

    // 5: simultaneous mode+inc at h=05
    press(1, 0);
    g = 0;
    while (mh != 5 && g < 30) begin press(0, 1); g++; end
    chk("t5_h05", ifc.bcd_h, 8'h05);
    press(1, 1);
    chk("t5_mod", {6'b0, ifc.mod}, 8'h02);
    chk("t5_h",   ifc.bcd_h, 8'h05);

    // 6: async reset in SET_M at m=37
    g = 0;
    while (mm != 37 && g < 70) begin press(0, 1); g++; end
    chk("t6_m37", ifc.bcd_m, 8'h37);
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_mod", {6'b0, ifc.mod}, 8'h00);
    chk("t6_h",   ifc.bcd_h, 8'h00);
    chk("t6_m",   ifc.bcd_m, 8'h00);
    chk("t6_s",   ifc.bcd_s, 8'h00);
    step();
    rst = 1'b0;

    // 7: long inc hold in SET_M from 00
    press(1, 0);
    press(1, 0);
    ifc.key_inc = 1'b1;
    g = 0;
    while (!lvl[1] && g < 20) begin step(); g++; end
    repeat (50) step();
    ifc.key_inc = 1'b0;
    repeat (10) step();
`ifdef AUTO_REPEAT_EN
    chk("t7_m", ifc.bcd_m, 8'h06);
`else
    chk("t7_m", ifc.bcd_m, 8'h01);
`endif

    // 8: random operations against the model
    for (int r = 0; r < 60; r++) begin
      op = int'($urandom_range(0, 4));
      case (op)
        0: repeat (int'($urandom_range(1, 30))) step();
        1: press(1, 0);
        2: press(0, 1);
        3: bounce_inc(int'($urandom_range(1, 4)));
        default: press(1, 1);
      endcase
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
